// File: rtl/pix_word_packer.sv
// Packs a valid/ready pixel stream into count-tagged words and writes them
// to the downstream register port at a rolling address.
module pix_word_packer #(
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned PIX_PER_WORD = 3,
  parameter int unsigned WORD_W       = 26,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned FLUSH_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              flush,
  input  logic              stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic [7:0]        word_cnt
);

  localparam int unsigned LANE_W = PIX_W * PIX_PER_WORD;
  localparam int unsigned CNT_W  = WORD_W - LANE_W;
  localparam int unsigned TO_W   = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIX_PER_WORD);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t              state;
  logic [LANE_W-1:0]   lanes;
  logic [CNT_W-1:0]    count;
  logic [TO_W-1:0]     timeout;
  logic [ADDR_W-1:0]   addr_ptr;

  logic                accept;
  logic [CNT_W-1:0]    count_inc;
  logic                word_full;
  logic [LANE_W-1:0]   lanes_ins;

  assign accept    = pix_valid && pix_ready;
  assign count_inc = count + CNT_W'(1);
  assign word_full = (count_inc == CNT_FULL);

  // Drop the incoming pixel into the lane selected by the current count.
  always_comb begin
    lanes_ins = lanes;
    for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
      if (count == CNT_W'(k)) lanes_ins[k*PIX_W +: PIX_W] = pix_in;
    end
  end

  // Packer FSM; pix_ready and busy are registered from the state being entered.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= IDLE;
      lanes     <= '0;
      count     <= '0;
      timeout   <= '0;
      addr_ptr  <= '0;
      pix_ready <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      word_cnt  <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          pix_ready <= !stall;
          if (accept) begin
            lanes   <= lanes_ins;
            count   <= count_inc;
            timeout <= '0;
            busy    <= 1'b1;
            if (flush) begin
              state     <= WRITE;
              pix_ready <= 1'b0;
            end else begin
              state <= FILL;
            end
          end
        end

        FILL: begin
          pix_ready <= !stall;
          if (accept) begin
            lanes   <= lanes_ins;
            count   <= count_inc;
            timeout <= '0;
            if (word_full || flush) begin
              state     <= WRITE;
              pix_ready <= 1'b0;
            end
          end else if (flush || (timeout == TO_LAST)) begin
            state     <= WRITE;
            pix_ready <= 1'b0;
          end else begin
            timeout <= timeout + TO_W'(1);
          end
        end

        WRITE: begin
          pix_ready <= 1'b0;
          if (!stall) begin
            wr_en     <= 1'b1;
            wr_data   <= {count, lanes};
            wr_addr   <= addr_ptr;
            addr_ptr  <= addr_ptr + ADDR_W'(1);
            word_cnt  <= word_cnt + 8'd1;
            lanes     <= '0;
            count     <= '0;
            timeout   <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
            pix_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          pix_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pix_word_packer.sv
// Randomized and directed bench for pix_word_packer against a pixel-grouping
// reference model built from queues.
module tb_pix_word_packer;

  localparam int FLUSH_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [25:0] wr_data;
  logic        busy;
  logic [7:0]  word_cnt;

  pix_word_packer dut (
    .clk(clk), .rstn(rstn), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .flush(flush), .stall(stall), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_cyc   = -1;
  int nwr      = 0;
  logic        last_acc;
  logic [25:0] last_wr_data;
  logic [2:0]  last_wr_addr;

  int          pend[$];
  int          idle_cnt = 0;
  logic [25:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // A finished word is the pixel count in the top bits over the pixels, first lowest.
  task automatic close_word();
    int w;
    w = pend.size() * (1 << 24);
    foreach (pend[k]) w += pend[k] * (1 << (8 * k));
    exp_q.push_back(26'(w));
    pend.delete();
    idle_cnt = 0;
  endtask

  task automatic model_edge(input logic acc, input logic [7:0] p, input logic f);
    if (acc) begin
      pend.push_back(int'(p));
      idle_cnt = 0;
      if (pend.size() == 3 || f) close_word();
    end else if (pend.size() > 0) begin
      if (f || idle_cnt == FLUSH_CYCLES - 1) close_word();
      else idle_cnt++;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] p, input logic f, input logic s);
    logic acc;
    logic [25:0] w;
    @(negedge clk);
    pix_valid = v; pix_in = p; flush = f; stall = s;
    acc = v && pix_ready;
    last_acc = acc;
    @(posedge clk);
    cyc++;
    model_edge(acc, p, f);
    #1;
    if (wr_en) begin
      wr_cyc = cyc;
      last_wr_data = wr_data;
      last_wr_addr = wr_addr;
      check("wr_while_stall", 32'(stall), 32'(0));
      check("wr_expected", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("wr_data", 32'(wr_data), 32'(w));
        check("wr_addr", 32'(wr_addr), 32'(nwr % 8));
        check("word_cnt", 32'(word_cnt), 32'((nwr + 1) % 256));
      end
      nwr++;
    end
    check("busy", 32'(busy), 32'(pend.size() > 0 || exp_q.size() > 0));
    if (exp_q.size() > 0) check("ready_in_write", 32'(pix_ready), 32'(0));
  endtask

  task automatic push(input logic [7:0] p, input logic f);
    step(1'b1, p, f, 1'b0);
    check("accepted", 32'(last_acc), 32'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() > 0 || pend.size() > 0); i++)
      step(1'b0, 8'h00, 1'b0, 1'b0);
    check("drain", 32'(exp_q.size() + pend.size()), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_valid = 1'b0; flush = 1'b0; stall = 1'b0; pix_in = '0;
    #2 rstn = 1'b1;
    #1;
    check("rst_wr_en", 32'(wr_en), 32'(0));
    check("rst_wr_addr", 32'(wr_addr), 32'(0));
    check("rst_word_cnt", 32'(word_cnt), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_pix_ready", 32'(pix_ready), 32'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    pend.delete();
    exp_q.delete();
    idle_cnt = 0;
    nwr = 0;
    wr_cyc = -1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a;
    int n0;
    logic v, f, s;
    int mode;

    do_reset();

    // Three back-to-back pixels, write one cycle after the third is taken.
    wr_cyc = -1;
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0);
    a = cyc;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("full_latency", 32'(wr_cyc), 32'(a + 1));
    check("full_data", 32'(last_wr_data), 32'(26'h3332211));
    check("full_addr", 32'(last_wr_addr), 32'(0));
    check("full_cnt", 32'(word_cnt), 32'(1));
    drain();

    // Explicit flush, alone and together with a pixel.
    push(8'hAB, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    drain();
    check("flush1_data", 32'(last_wr_data), 32'(26'h10000AB));
    push(8'h01, 1'b0);
    push(8'hCD, 1'b1);
    drain();
    check("flush2_data", 32'(last_wr_data), 32'(26'h200CD01));
    push(8'h44, 1'b1);
    a = cyc;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_flush_lat", 32'(wr_cyc), 32'(a + 1));
    check("idle_flush_data", 32'(last_wr_data), 32'(26'h1000044));

    // Idle timeout, then a late pixel restarting it.
    wr_cyc = -1;
    push(8'h5A, 1'b0);
    a = cyc;
    repeat (16) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("to_not_early", 32'(wr_cyc), 32'(-1));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("to_latency", 32'(wr_cyc), 32'(a + 17));
    check("to_data", 32'(last_wr_data), 32'(26'h100005A));
    push(8'h77, 1'b0);
    repeat (14) step(1'b0, 8'h00, 1'b0, 1'b0);
    wr_cyc = -1;
    push(8'h88, 1'b0);
    a = cyc;
    repeat (16) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("to_restart_early", 32'(wr_cyc), 32'(-1));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("to_restart_lat", 32'(wr_cyc), 32'(a + 17));
    check("to_restart_data", 32'(last_wr_data), 32'(26'h2008877));

    // Reset in the middle of a partial word discards it.
    push(8'h99, 1'b0); push(8'h98, 1'b0);
    do_reset();
    repeat (30) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_no_write", 32'(nwr), 32'(0));
    check("rst_addr_hold", 32'(wr_addr), 32'(0));

    // Stall held in WRITE for five cycles, then exactly one write.
    push(8'hA1, 1'b0); push(8'hA2, 1'b0); push(8'hA3, 1'b0);
    n0 = nwr;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("stall_wr_en", 32'(wr_en), 32'(0));
      check("stall_ready", 32'(pix_ready), 32'(0));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("stall_one_write", 32'(nwr), 32'(n0 + 1));
    check("stall_data", 32'(last_wr_data), 32'(26'h3A3A2A1));

    // Nine full words from reset: address wraps back to 0.
    do_reset();
    for (int w = 0; w < 9; w++) begin
      for (int k = 0; k < 3; k++) push(8'($urandom), 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("wrap_nwr", 32'(nwr), 32'(9));
    check("wrap_addr", 32'(last_wr_addr), 32'(0));
    check("wrap_cnt", 32'(word_cnt), 32'(9));

    // Random traffic with flush, stall and sparse stretches.
    for (int blk = 0; blk < 40; blk++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < 60; i++) begin
        v = (mode == 0) ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 70);
        f = ($urandom_range(0, 99) < 5);
        s = ($urandom_range(0, 99) < 10);
        step(v, 8'($urandom), f, s);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
